seg_scan_decoder: RTL and testbench

//  Receive-side counterpart of the 4-digit multiplexed 7-segment scanner in the ball game.
//  - Samples the select/seg pin bundle and recovers the four displayed digit codes.
//  - Publishes the recovered codes as one 16-bit score word per completed scan frame.
//  - Flags illegal segment patterns, illegal selects and a stalled scan.
//  - Used as an on-chip score monitor and as the checker end of display loopback tests.

---
 rtl/seg_scan_decoder.sv | 142 ++++++++++++++
 tb/tb_seg_scan_decoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Receive side of a 4-digit multiplexed 7-segment scanner: recovers the displayed
// digit codes from the select/seg pins and publishes one 16-bit score word per frame.
module seg_scan_decoder #(
   parameter int SETTLE  = 4,
   parameter int TIMEOUT = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  select_in,
   input  logic [6:0]  seg_in,
   input  logic        err_clr,
   output logic [15:0] digits,
   output logic        frame_done,
   output logic [3:0]  digit_valid,
   output logic        code_err,
   output logic        sel_err,
   output logic        stale
);

   localparam int CW = $clog2(SETTLE + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   // bit 4 flags a pattern outside the legal table
   function automatic logic [4:0] decode_seg(input logic [6:0] s);
      case (s)
         7'h3F:   return 5'h00;
         7'h06:   return 5'h01;
         7'h5B:   return 5'h02;
         7'h4F:   return 5'h03;
         7'h66:   return 5'h04;
         7'h6D:   return 5'h05;
         7'h7D:   return 5'h06;
         7'h07:   return 5'h07;
         7'h7F:   return 5'h08;
         7'h6F:   return 5'h09;
         7'h40:   return 5'h0A;
         7'h00:   return 5'h0B;
         default: return 5'h1F;
      endcase
   endfunction

   // {valid, index}; valid only for a one-hot-low select
   function automatic logic [2:0] sel_index(input logic [3:0] s);
      case (s)
         4'b0111: return 3'b100;
         4'b1011: return 3'b101;
         4'b1101: return 3'b110;
         4'b1110: return 3'b111;
         default: return 3'b000;
      endcase
   endfunction

   logic [3:0]      sel_p0, sel_p1, sel_p2;
   logic [6:0]      seg_p0, seg_p1, seg_p2;
   logic [1:0]      primed;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_nxt;
   logic [TW-1:0]   stale_cnt;
   logic [3:0][3:0] shadow;
   logic            changed;
   logic            strobe;
   logic            accept;
   logic            sel_bad;
   logic [4:0]      dec;
   logic [2:0]      sidx;
   logic [3:0]      bitmask;

   always_comb begin
      changed = ({sel_p1, seg_p1} != {sel_p2, seg_p2});
      cnt_nxt = cnt;
      if (changed)
         cnt_nxt = '0;
      else if (cnt != CW'(SETTLE))
         cnt_nxt = cnt + 1'b1;
      // primed masks the synchronizer's reset value from being taken as a real strobe
      strobe  = primed[1] && (cnt_nxt == CW'(SETTLE - 1));
      dec     = decode_seg(seg_p1);
      sidx    = sel_index(sel_p1);
      accept  = strobe && sidx[2];
      sel_bad = strobe && !sidx[2] && (sel_p1 != 4'b1111);
      bitmask = 4'b0001 << sidx[1:0];
   end

   assign stale = (stale_cnt == TW'(TIMEOUT));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sel_p0      <= '0;
         sel_p1      <= '0;
         sel_p2      <= '0;
         seg_p0      <= '0;
         seg_p1      <= '0;
         seg_p2      <= '0;
         primed      <= '0;
         cnt         <= '0;
         stale_cnt   <= '0;
         shadow      <= '0;
         digits      <= '0;
         frame_done  <= 1'b0;
         digit_valid <= '0;
         code_err    <= 1'b0;
         sel_err     <= 1'b0;
      end else begin
         // p0/p1: synchronizer, p2: previous synced value for change detection
         sel_p0 <= select_in;
         sel_p1 <= sel_p0;
         sel_p2 <= sel_p1;
         seg_p0 <= seg_in;
         seg_p1 <= seg_p0;
         seg_p2 <= seg_p1;
         primed <= {primed[0], 1'b1};
         cnt    <= cnt_nxt;

         frame_done <= (digit_valid == 4'hF);
         if (digit_valid == 4'hF) begin
            digits      <= shadow;
            digit_valid <= accept ? bitmask : 4'h0;
         end else if (accept) begin
            digit_valid <= digit_valid | bitmask;
         end

         if (accept)
            shadow[sidx[1:0]] <= dec[3:0];

         if (accept && dec[4])
            code_err <= 1'b1;
         else if (err_clr)
            code_err <= 1'b0;

         if (sel_bad)
            sel_err <= 1'b1;
         else if (err_clr)
            sel_err <= 1'b0;

         if (accept)
            stale_cnt <= '0;
         else if (stale_cnt != TW'(TIMEOUT))
            stale_cnt <= stale_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder; frame words are scoreboarded through a queue.
module tb_seg_scan_decoder;

   localparam int SETTLE  = 4;
   localparam int TIMEOUT = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  select_in;
   logic [6:0]  seg_in;
   logic        err_clr;
   logic [15:0] digits;
   logic        frame_done;
   logic [3:0]  digit_valid;
   logic        code_err;
   logic        sel_err;
   logic        stale;

   int          checks = 0;
   int          fails  = 0;
   int          frames = 0;
   logic [15:0] exp_q[$];

   seg_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .select_in(select_in), .seg_in(seg_in), .err_clr(err_clr),
      .digits(digits), .frame_done(frame_done), .digit_valid(digit_valid),
      .code_err(code_err), .sel_err(sel_err), .stale(stale)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [3:0] s, input logic [6:0] g, input int n);
      select_in = s;
      seg_in    = g;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic scan(input logic [6:0] g0, input logic [6:0] g1,
                       input logic [6:0] g2, input logic [6:0] g3);
      drive(4'b0111, g0, 8);
      drive(4'b1011, g1, 8);
      drive(4'b1101, g2, 8);
      drive(4'b1110, g3, 8);
   endtask

   always @(negedge clk) begin
      if (rst && frame_done) begin
         frames++;
         if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $error("FAIL frame_unexpected observed=%h expected=none", digits);
         end else begin
            chk("frame_digits", digits, exp_q.pop_front());
         end
      end
   end

   initial begin
      select_in = 4'hF;
      seg_in    = 7'h00;
      err_clr   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_digits", digits, 16'h0000);
      chk("rst_frame_done", 16'(frame_done), 16'h0);
      chk("rst_valid", 16'(digit_valid), 16'h0);
      chk("rst_code_err", 16'(code_err), 16'h0);
      chk("rst_sel_err", 16'(sel_err), 16'h0);
      chk("rst_stale", 16'(stale), 16'h0);
      rst = 1'b1;
      drive(4'hF, 7'h00, 4);

      // continuous scan of 0 / dash / blank / 1
      repeat (3) begin
         exp_q.push_back(16'h1BA0);
         scan(7'h3F, 7'h40, 7'h00, 7'h06);
      end
      chk("scan_frames", 16'(frames), 16'd3);
      chk("scan_code_err", 16'(code_err), 16'h0);
      chk("scan_sel_err", 16'(sel_err), 16'h0);

      // short glitch of 2 must not be captured
      exp_q.push_back(16'h1B40);
      drive(4'b1011, 7'h5B, SETTLE - 1);
      drive(4'b1011, 7'h66, 8);
      chk("glitch_valid", 16'(digit_valid), 16'h0002);
      drive(4'b0111, 7'h3F, 8);
      drive(4'b1101, 7'h00, 8);
      drive(4'b1110, 7'h06, 8);
      chk("glitch_frames", 16'(frames), 16'd4);

      // illegal pattern on digit2
      exp_q.push_back(16'h1FA0);
      scan(7'h3F, 7'h40, 7'h55, 7'h06);
      chk("bad_code_err", 16'(code_err), 16'h1);
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      chk("clr_code_err", 16'(code_err), 16'h0);
      chk("bad_code_frames", 16'(frames), 16'd5);

      // two selects low, then idle select
      drive(4'b0011, 7'h3F, 8);
      chk("multi_sel_err", 16'(sel_err), 16'h1);
      chk("multi_sel_valid", 16'(digit_valid), 16'h0);
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      chk("clr_sel_err", 16'(sel_err), 16'h0);
      drive(4'b1111, 7'h00, 8);
      chk("idle_sel_err", 16'(sel_err), 16'h0);
      chk("idle_code_err", 16'(code_err), 16'h0);
      chk("idle_valid", 16'(digit_valid), 16'h0);
      chk("idle_frames", 16'(frames), 16'd5);

      // stall detection: last accept lands 3 edges before the scan returns
      exp_q.push_back(16'h1BA0);
      scan(7'h3F, 7'h40, 7'h00, 7'h06);
      chk("pre_stale", 16'(stale), 16'h0);
      repeat (TIMEOUT - 3) @(posedge clk);
      #1;
      chk("stale_early", 16'(stale), 16'h0);
      @(posedge clk);
      #1;
      chk("stale_set", 16'(stale), 16'h1);
      exp_q.push_back(16'h1BA0);
      drive(4'b0111, 7'h3F, SETTLE + 1);
      chk("stale_hold", 16'(stale), 16'h1);
      drive(4'b0111, 7'h3F, 1);
      chk("stale_clear", 16'(stale), 16'h0);
      drive(4'b0111, 7'h3F, 2);
      drive(4'b1011, 7'h40, 8);
      drive(4'b1101, 7'h00, 8);
      drive(4'b1110, 7'h06, 8);
      chk("resume_frames", 16'(frames), 16'd7);

      // reset in the middle of a frame
      drive(4'b1011, 7'h40, 8);
      drive(4'b1101, 7'h00, 8);
      chk("mid_valid", 16'(digit_valid), 16'h0006);
      rst = 1'b0;
      #1;
      chk("mid_rst_digits", digits, 16'h0000);
      chk("mid_rst_valid", 16'(digit_valid), 16'h0);
      chk("mid_rst_flags", 16'({frame_done, code_err, sel_err, stale}), 16'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      drive(4'b1110, 7'h06, 8);
      drive(4'b0111, 7'h3F, 8);
      chk("post_rst_valid", 16'(digit_valid), 16'h0009);
      chk("post_rst_frames", 16'(frames), 16'd7);
      exp_q.push_back(16'h1BA0);
      drive(4'b1011, 7'h40, 8);
      drive(4'b1101, 7'h00, 8);
      chk("post_rst_frame", 16'(frames), 16'd8);
      chk("post_rst_digits", digits, 16'h1BA0);
      chk("queue_empty", 16'(exp_q.size()), 16'h0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
